// File: rtl/neuron_mac_accumulate.sv
// neuron_mac_accumulate: multiplies each neuron input by its weight and accumulates the products in signed fixed point.
// Each finished vector gets the bias added, is saturated, optionally passed through ReLU, and is flagged with an output_valid pulse.
`default_nettype none

module neuron_mac_accumulate #(
  parameter int DATA_BITS   = 16,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_WEIGHTS = 784,
  parameter int LAYER_NO    = 0,
  parameter int NEURON_NO   = 0,
  parameter int BIAS_INIT   = 0,
  parameter bit ACT_RELU    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] neuron_in,
  input  logic                 neuron_in_valid,
  input  logic [DATA_BITS-1:0] weight_out,
  input  logic                 bias_valid,
  input  logic [31:0]          bias_value,
  input  logic [31:0]          config_layer_no,
  input  logic [31:0]          config_neuron_no,
  output logic [DATA_BITS-1:0] neuron_out,
  output logic                 output_valid
);

  localparam int MUL_W = 2 * DATA_BITS;
  localparam int CNT_W = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
  localparam int ACC_W = MUL_W + $clog2(NUM_WEIGHTS) + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WEIGHTS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_BITS+1){1'b0}}, {(DATA_BITS-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_BITS+1){1'b1}}, {(DATA_BITS-1){1'b0}}};

  logic [DATA_BITS-1:0]     in_d;
  logic                     vld_d;
  logic signed [MUL_W-1:0]  mul_r;
  logic                     mul_vld;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;
  logic [DATA_BITS-1:0]     bias_r;
  logic signed [SUM_W-1:0]  sum_r;
  logic                     fin_vld;

  logic signed [ACC_W-1:0]  acc_next;
  logic signed [SUM_W-1:0]  bias_shifted;
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [SUM_W-1:0]  shifted;
  logic [DATA_BITS-1:0]     result;
  logic                     bias_hit;
  logic                     unused_bias_hi;

  assign unused_bias_hi = ^bias_value[31:DATA_BITS];
  assign bias_hit = bias_valid && (config_layer_no == 32'(LAYER_NO))
                    && (config_neuron_no == 32'(NEURON_NO));

  assign acc_next     = acc + {{(ACC_W-MUL_W){mul_r[MUL_W-1]}}, mul_r};
  // Bias is aligned to the product's Q format (2*FRAC_BITS) before shifting back.
  assign bias_shifted = {{(SUM_W-DATA_BITS-FRAC_BITS){bias_r[DATA_BITS-1]}},
                         bias_r, {FRAC_BITS{1'b0}}};
  assign sum_next     = {acc_next[ACC_W-1], acc_next} + bias_shifted;
  assign shifted      = sum_r >>> FRAC_BITS;

  always_comb begin
    result = shifted[DATA_BITS-1:0];
    if (shifted > SAT_MAX) begin
      result = {1'b0, {(DATA_BITS-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      result = {1'b1, {(DATA_BITS-1){1'b0}}};
    end
    if (ACT_RELU && result[DATA_BITS-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_d         <= '0;
      vld_d        <= 1'b0;
      mul_r        <= '0;
      mul_vld      <= 1'b0;
      acc          <= '0;
      count        <= '0;
      bias_r       <= DATA_BITS'(BIAS_INIT);
      sum_r        <= '0;
      fin_vld      <= 1'b0;
      neuron_out   <= '0;
      output_valid <= 1'b0;
    end else begin
      in_d    <= neuron_in;
      vld_d   <= neuron_in_valid;
      mul_r   <= $signed(in_d) * $signed(weight_out);
      mul_vld <= vld_d;
      fin_vld <= 1'b0;

      if (mul_vld) begin
        if (count == LAST_CNT) begin
          sum_r   <= sum_next;
          fin_vld <= 1'b1;
          acc     <= '0;
          count   <= '0;
        end else begin
          acc   <= acc_next;
          count <= count + 1'b1;
        end
      end

      // A write on the completion edge lands after sum_r has used the old bias.
      if (bias_hit) begin
        bias_r <= bias_value[DATA_BITS-1:0];
      end

      output_valid <= fin_vld;
      if (fin_vld) begin
        neuron_out <= result;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_accumulate.sv
// Testbench for neuron_mac_accumulate. Two instances, one with ReLU and one linear, are checked against an integer model of the neuron.
`default_nettype none

module tb_neuron_mac_accumulate;

  localparam int N   = 4;
  localparam int LNO = 1;
  localparam int NNO = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] neuron_in = '0;
  logic        neuron_in_valid = 1'b0;
  logic [15:0] weight_out = '0;
  logic        bias_valid = 1'b0;
  logic [31:0] bias_value = '0;
  logic [31:0] config_layer_no = '0;
  logic [31:0] config_neuron_no = '0;
  logic [15:0] out_r, out_l;
  logic        ov_r, ov_l;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  neuron_mac_accumulate #(.DATA_BITS(16), .FRAC_BITS(8), .NUM_WEIGHTS(N), .LAYER_NO(LNO),
    .NEURON_NO(NNO), .BIAS_INIT(0), .ACT_RELU(1'b1)) dut_relu (
    .clk(clk), .reset(reset), .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
    .weight_out(weight_out), .bias_valid(bias_valid), .bias_value(bias_value),
    .config_layer_no(config_layer_no), .config_neuron_no(config_neuron_no),
    .neuron_out(out_r), .output_valid(ov_r));

  neuron_mac_accumulate #(.DATA_BITS(16), .FRAC_BITS(8), .NUM_WEIGHTS(N), .LAYER_NO(LNO),
    .NEURON_NO(NNO), .BIAS_INIT(0), .ACT_RELU(1'b0)) dut_lin (
    .clk(clk), .reset(reset), .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
    .weight_out(weight_out), .bias_valid(bias_valid), .bias_value(bias_value),
    .config_layer_no(config_layer_no), .config_neuron_no(config_neuron_no),
    .neuron_out(out_l), .output_valid(ov_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] activate(input longint sum, input bit relu);
    longint s;
    s = sum >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[15:0];
  endfunction

  // Model: products paired with the weight that arrives one cycle after each
  // sample; the finished sum takes the bias held just before the completion
  // edge and appears on the outputs one cycle later.
  longint      m_acc = 0, m_fin_acc = 0, m_out_sum = 0, m_bias = 0;
  int          m_cnt = 0;
  bit          m_prev_v = 0, m_fin_pend = 0, m_out_pend = 0, m_live = 0;
  logic [15:0] m_prev_in = '0;
  logic        exp_v = 1'b0;
  logic [15:0] exp_r = '0, exp_l = '0;

  always @(posedge clk) begin
    m_live = 1;
    if (reset) begin
      m_acc = 0; m_cnt = 0; m_prev_v = 0; m_fin_pend = 0; m_out_pend = 0;
      m_bias = 0; exp_v = 1'b0; exp_r = '0; exp_l = '0;
    end else begin
      exp_v = 1'b0;
      if (m_out_pend) begin
        exp_r = activate(m_out_sum, 1'b1);
        exp_l = activate(m_out_sum, 1'b0);
        exp_v = 1'b1;
        m_out_pend = 0;
      end
      if (m_fin_pend) begin
        m_out_sum = m_fin_acc + m_bias * 256;
        m_out_pend = 1;
        m_fin_pend = 0;
      end
      if (m_prev_v) begin
        m_acc += longint'($signed(m_prev_in)) * longint'($signed(weight_out));
        m_cnt++;
        if (m_cnt == N) begin
          m_fin_acc = m_acc; m_fin_pend = 1; m_acc = 0; m_cnt = 0;
        end
      end
      if (bias_valid && config_layer_no == LNO && config_neuron_no == NNO)
        m_bias = longint'($signed(bias_value[15:0]));
      m_prev_v = neuron_in_valid;
      m_prev_in = neuron_in;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("valid_relu", {31'b0, ov_r}, {31'b0, exp_v});
      chk("valid_lin",  {31'b0, ov_l}, {31'b0, exp_v});
      chk("out_relu",   {16'b0, out_r}, {16'b0, exp_r});
      chk("out_lin",    {16'b0, out_l}, {16'b0, exp_l});
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] w);
    neuron_in = x;
    neuron_in_valid = 1'b1;
    @(posedge clk); #1;
    weight_out = w;
    neuron_in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    weight_out = 16'hDEAD;
  endtask

  task automatic write_bias(input logic [31:0] val, input int layer, input int neuron);
    bias_valid = 1'b1;
    bias_value = val;
    config_layer_no = 32'(layer);
    config_neuron_no = 32'(neuron);
    @(posedge clk); #1;
    bias_valid = 1'b0;
  endtask

  // Literal checks of one vector: value from both instances and the
  // 4th negedge after the last sampling edge as the output cycle.
  task automatic run_vector(input string name, input logic [15:0] x, input logic [15:0] w,
                            input int gap, input bit coinc,
                            input logic [15:0] want_r, input logic [15:0] want_l);
    int k;
    for (int i = 0; i < N; i++) begin
      send(x, w);
      if (i != N - 1) repeat (gap) idle();
    end
    k = 0;
    while (k < 12) begin
      @(negedge clk);
      k++;
      if (coinc && k == 2) begin
        bias_valid = 1'b1; bias_value = 32'h80;
        config_layer_no = 32'(LNO); config_neuron_no = 32'(NNO);
      end
      if (k == 3) bias_valid = 1'b0;
      if (ov_r) break;
    end
    chk({name, "_latency"}, 32'(k), 32'd4);
    chk({name, "_relu"}, {16'b0, out_r}, {16'b0, want_r});
    chk({name, "_lin"},  {16'b0, out_l}, {16'b0, want_l});
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_out_relu", {16'b0, out_r}, 32'h0);
    chk("reset_out_lin", {16'b0, out_l}, 32'h0);
    chk("reset_valid", {30'b0, ov_r, ov_l}, 32'h0);
    idle();

    run_vector("identity", 16'h0100, 16'h0100, 0, 1'b0, 16'h0400, 16'h0400);
    run_vector("negative", 16'h0100, 16'hFF00, 0, 1'b0, 16'h0000, 16'hFC00);
    run_vector("sat_pos", 16'h7FFF, 16'h7FFF, 0, 1'b0, 16'h7FFF, 16'h7FFF);
    run_vector("sat_neg", 16'h7FFF, 16'h8000, 0, 1'b0, 16'h0000, 16'h8000);

    write_bias(32'h80, LNO, NNO + 1);
    write_bias(32'h80, LNO + 1, NNO);
    run_vector("bias_miss", 16'h0100, 16'h0100, 0, 1'b0, 16'h0400, 16'h0400);
    write_bias(32'h80, LNO, NNO);
    run_vector("bias_hit", 16'h0100, 16'h0100, 0, 1'b0, 16'h0480, 16'h0480);
    write_bias(32'h0, LNO, NNO);
    run_vector("bias_coinc", 16'h0100, 16'h0100, 0, 1'b1, 16'h0400, 16'h0400);
    run_vector("bias_after", 16'h0100, 16'h0100, 0, 1'b0, 16'h0480, 16'h0480);

    run_vector("gaps", 16'h0100, 16'h0100, 2, 1'b0, 16'h0480, 16'h0480);

    send(16'h0100, 16'h0100);
    send(16'h0100, 16'h0100);
    idle(); idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    idle();
    run_vector("after_reset", 16'h0100, 16'h0100, 0, 1'b0, 16'h0400, 16'h0400);
    run_vector("b2b_second", 16'h0200, 16'h0100, 0, 1'b0, 16'h0800, 16'h0800);

    repeat (5) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/neuron_mac_accumulate.md
Name: neuron_mac_accumulate

Overview:
Downstream consumer of a neuron's weight memory control block. It pairs each neuron input with the weight read out for it, and multiply-accumulates num_weights products in signed fixed point. It then adds the neuron's bias and applies saturation plus optional ReLU. Its output_valid pulse also returns to the weight memory control to rewind the read address for the next input vector.

Parameters:
data_bits, 16, width of inputs, weights, bias and neuron_out (signed two's complement)
frac_bits, 8, fractional bits of the shared Q format
num_weights, 784, products per input vector
layer_no, 0, layer index this neuron answers to on the config bus
neuron_no, 0, neuron index this neuron answers to on the config bus
bias_init, 0, reset value of the bias register (data_bits, signed)
act_relu, 1, 1 = ReLU after saturation, 0 = saturated linear output

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
neuron_in  input  data_bits  signed input sample
neuron_in_valid  input  1  neuron_in valid; same signal drives the weight memory read enable
weight_out  input  data_bits  registered weight memory output; valid the cycle after neuron_in_valid
bias_valid  input  1  config bus bias write strobe
bias_value  input  32  bias word, zero-padded; low data_bits used
config_layer_no  input  32  config target layer
config_neuron_no  input  32  config target neuron
neuron_out  output  data_bits  activated result, held until next result
output_valid  output  1  one-cycle pulse when neuron_out updates

Behaviour:
- Reset (sync, clk): neuron_out=0, output_valid=0, acc=0, count=0, all pipeline valids=0, bias_r=bias_init. Reset mid-vector discards the partial sum; no output_valid is produced for it.
- Bias write: at a clk edge with bias_valid & config_layer_no==layer_no & config_neuron_no==neuron_no, bias_r <= bias_value[data_bits-1:0]. Otherwise bias_r is unchanged.
- Pipeline, edges numbered from E0, the edge that samples neuron_in_valid=1:
  - E0: in_d <= neuron_in, vld_d <= neuron_in_valid.
  - E1: mul_r <= signed(in_d)*signed(weight_out) (2*data_bits), mul_vld <= vld_d.
  - E2 (mul_vld=1): count <= count+1; acc <= acc + sext(mul_r). acc width = 2*data_bits + clog2(num_weights) + 1.
- Completion, at the E2 where count==num_weights-1:
  - sum_r <= acc + sext(mul_r) + (sext(bias_r) << frac_bits); fin_vld <= 1.
  - acc <= 0, count <= 0.
  - bias_r is sampled as its pre-edge value, so a bias write on the same edge applies to the next vector.
- E3 (fin_vld=1):
  - s = sum_r >>> frac_bits (arithmetic shift, truncation toward -inf).
  - Saturate s to [-2^(data_bits-1), 2^(data_bits-1)-1].
  - If act_relu, negative results become 0.
  - neuron_out <= result; output_valid <= 1 for exactly one cycle.
- Latency: output_valid is high in the cycle after the 3rd rising edge following the edge that sampled the last input. Fixed regardless of gaps.
- neuron_in_valid may have arbitrary idle gaps within a vector; count only advances on valid samples.
- Vector boundary: the next vector's first product may reach E2 on the edge after completion; acc starts from 0, so vectors are independent.
- System rule: the next vector must not start before the cycle after output_valid, because the weight memory read address rewinds on output_valid.
- No handshake backpressure; neuron_out holds until the next completion.

Test Plan:
- Identity (num_weights=4, frac_bits=8, act_relu=1): in=0x0100 ×4, weight=0x0100, bias=0 -> neuron_out=0x0400; output_valid pulses 1 cycle, 3 edges after the last input edge.
- Sign/ReLU: in=0x0100, weight=0xFF00 ×4 -> act_relu=1: 0x0000; act_relu=0: 0xFC00.
- Saturation: in=weight=0x7FFF ×4 -> 0x7FFF; in=0x7FFF, weight=0x8000, act_relu=0 -> 0x8000.
- Bias config: bias_valid with matching layer/neuron, value 0x00000080 -> identity case gives 0x0480. Same write with config_neuron_no=neuron_no+1 -> still 0x0400. Write coincident with the completion edge -> takes effect on the next vector only.
- Gaps/reset: identity vector with 2 idle cycles between samples -> 0x0400 at fixed latency. Reset after 2 of 4 inputs, then a full vector -> single output_valid, neuron_out=0x0400.
- Back-to-back: identity vector then in=0x0200 ×4 starting the cycle after output_valid -> 0x0400 then 0x0800, no cross-contamination.
